// File: rtl/fibgen_seq_ctrl.sv
// Run controller for the Fibonacci generator datapath: clears the generator, steps
// it one term per cycle, and reports the last term, its index and overflow status.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last run's result
// CLEAR | one cycle, generator cleared so F0 appears next cycle
// RUN   | one term per cycle, watching for overflow or the last term
// DONE  | one-cycle completion pulse
module fibgen_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int LIMIT = 128
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_terms_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] fib_value_i,
    output logic             fib_clr_o,
    output logic             fib_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] result_o,
    output logic [CNT_W-1:0] term_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic over_limit;
    logic last_term;

    assign over_limit = (fib_value_i > LIMIT_V);
    assign last_term  = (idx_q == (n_q - CNT_W'(1)));

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        fib_clr_o = 1'b0;
        fib_en_o  = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    if (num_terms_i != '0) begin
                        n_d     = num_terms_i;
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                busy_o    = 1'b1;
                // Gated by reset so the generator sees no command during a reset cycle.
                fib_clr_o = ~reset_i;
                idx_d     = '0;
                state_d   = abort_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (over_limit) begin
                    ovf_d    = 1'b1;
                    result_d = fib_value_i;
                    state_d  = S_DONE;
                end else if (last_term) begin
                    result_d = fib_value_i;
                    state_d  = S_DONE;
                end else begin
                    fib_en_o = ~reset_i;
                    idx_d    = idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ovf_o      = ovf_q;
    assign result_o   = result_q;
    assign term_idx_o = idx_q;

endmodule

// File: tb/tb_fibgen_seq_ctrl.sv
// Bench for fibgen_seq_ctrl: a behavioural generator datapath plus directed and
// randomized runs checked against a Fibonacci reference model.
module tb_fibgen_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int LIMIT = 128;
    localparam int WIN   = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] fv = '0;
    logic [WIDTH-1:0] fnext = '0;
    logic             fib_clr, fib_en, busy, done, ovf;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] term_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fibgen_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LIMIT(LIMIT)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .start_i     (start),
        .num_terms_i (num),
        .abort_i     (abort),
        .fib_value_i (fv),
        .fib_clr_o   (fib_clr),
        .fib_en_o    (fib_en),
        .busy_o      (busy),
        .done_o      (done),
        .ovf_o       (ovf),
        .result_o    (result),
        .term_idx_o  (term_idx)
    );

    // Generator datapath: registered value with a hidden "next" term.
    always_ff @(posedge clk) begin
        if (fib_clr) begin
            fv    <= '0;
            fnext <= 8'd1;
        end else if (fib_en) begin
            fv    <= fnext;
            fnext <= fv + fnext;
        end
    end

    // Expected outcome of an unaborted run of n terms, k counted in cycles after the start edge.
    function automatic void ref_run(input int n, output int done_k, output int en_cnt,
                                    output int res, output int ovf_e, output int idx);
        int a, b, t;
        a = 0; b = 1;
        done_k = 1; en_cnt = 0; res = 0; ovf_e = 0; idx = 0;
        for (int i = 0; i < n; i++) begin
            if (a > LIMIT) begin
                ovf_e = 1; res = a; idx = i; done_k = i + 3; en_cnt = i;
                return;
            end
            if (i == n - 1) begin
                res = a; idx = i; done_k = n + 2; en_cnt = n - 1;
                return;
            end
            t = (a + b) % 256;
            a = b;
            b = t;
        end
    endfunction

    task automatic run_obs(input int n, input int n_alt, input int abort_k, input int again_k,
                           input bit start_with_abort,
                           output int done_k, output int done_cnt, output int clr_cnt,
                           output int en_cnt, output int en_last, output int busy_cnt);
        @(posedge clk);
        #1 start = 1'b1; num = CNT_W'(n); abort = start_with_abort;
        @(posedge clk);
        done_k = -1; done_cnt = 0; clr_cnt = 0; en_cnt = 0; en_last = -1; busy_cnt = 0;
        for (int k = 1; k <= WIN; k++) begin
            #1;
            start = (k == again_k);
            num   = CNT_W'(n_alt);
            abort = (k == abort_k);
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (fib_clr) clr_cnt++;
            if (fib_en) begin
                en_cnt++;
                en_last = k;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
        end
        #1 start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (fib_clr !== 1'b0) begin bad++; $display("FAIL reset_fib_clr: got %0b want 0", fib_clr); end
        total++; if (fib_en !== 1'b0) begin bad++; $display("FAIL reset_fib_en: got %0b want 0", fib_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
        total++; if (term_idx !== '0) begin bad++; $display("FAIL reset_term_idx: got %0d want 0", term_idx); end
        #1 rst = 1'b0;
    endtask

    task automatic test_single_term;
        int dk, dc, cc, ec, el, bc;
        run_obs(1, 9, 0, 0, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 3) begin bad++; $display("FAIL n1_done_k: got %0d want 3", dk); end
        total++; if (cc !== 1) begin bad++; $display("FAIL n1_clr_cycles: got %0d want 1", cc); end
        total++; if (ec !== 0) begin bad++; $display("FAIL n1_en_cycles: got %0d want 0", ec); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL n1_result: got %0d want 0", result); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL n1_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_ten_terms;
        int dk, dc, cc, ec, el, bc;
        run_obs(10, 3, 0, 0, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 12) begin bad++; $display("FAIL n10_done_k: got %0d want 12", dk); end
        total++; if (ec !== 9) begin bad++; $display("FAIL n10_en_cycles: got %0d want 9", ec); end
        total++; if (bc !== 11) begin bad++; $display("FAIL n10_busy_cycles: got %0d want 11", bc); end
        total++; if (result !== 8'd34) begin bad++; $display("FAIL n10_result: got %0d want 34", result); end
        total++; if (term_idx !== 8'd9) begin bad++; $display("FAIL n10_term_idx: got %0d want 9", term_idx); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL n10_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_overflow;
        int dk, dc, cc, ec, el, bc;
        run_obs(20, 1, 0, 0, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 15) begin bad++; $display("FAIL ovf_done_k: got %0d want 15", dk); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
        total++; if (result !== 8'd144) begin bad++; $display("FAIL ovf_result: got %0d want 144", result); end
        total++; if (term_idx !== 8'd12) begin bad++; $display("FAIL ovf_term_idx: got %0d want 12", term_idx); end
        total++; if (ec !== 12) begin bad++; $display("FAIL ovf_en_cycles: got %0d want 12", ec); end
    endtask

    task automatic test_zero_terms;
        int dk, dc, cc, ec, el, bc;
        run_obs(0, 5, 0, 0, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 1) begin bad++; $display("FAIL n0_done_k: got %0d want 1", dk); end
        total++; if (cc !== 0) begin bad++; $display("FAIL n0_clr_cycles: got %0d want 0", cc); end
        total++; if (bc !== 0) begin bad++; $display("FAIL n0_busy_cycles: got %0d want 0", bc); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL n0_result: got %0d want 0", result); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL n0_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_abort;
        int dk, dc, cc, ec, el, bc;
        run_obs(10, 10, 6, 0, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dc !== 0) begin bad++; $display("FAIL abort_done_pulses: got %0d want 0", dc); end
        total++; if (el !== 5) begin bad++; $display("FAIL abort_last_en_k: got %0d want 5", el); end
        total++; if (ec !== 4) begin bad++; $display("FAIL abort_en_cycles: got %0d want 4", ec); end
        total++; if (bc !== 6) begin bad++; $display("FAIL abort_busy_cycles: got %0d want 6", bc); end
        total++; if (term_idx !== 8'd4) begin bad++; $display("FAIL abort_term_idx: got %0d want 4", term_idx); end
    endtask

    task automatic test_start_with_abort;
        int dk, dc, cc, ec, el, bc;
        run_obs(3, 3, 0, 0, 1'b1, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 5) begin bad++; $display("FAIL sa_done_k: got %0d want 5", dk); end
        total++; if (result !== 8'd1) begin bad++; $display("FAIL sa_result: got %0d want 1", result); end
    endtask

    task automatic test_reset_mid_run;
        int dk, dc, cc, ec, el, bc, dcount;
        @(posedge clk);
        #1 start = 1'b1; num = 8'd15;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++; if (fib_en !== 1'b0) begin bad++; $display("FAIL rmid_fib_en_same_cycle: got %0b want 0", fib_en); end
        total++; if (fib_clr !== 1'b0) begin bad++; $display("FAIL rmid_fib_clr_same_cycle: got %0b want 0", fib_clr); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        total++; if (term_idx !== '0) begin bad++; $display("FAIL rmid_term_idx: got %0d want 0", term_idx); end
        total++; if (result !== '0 || ovf !== 1'b0) begin bad++; $display("FAIL rmid_result_ovf: got %0d/%0b want 0/0", result, ovf); end
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        total++; if (dcount !== 0) begin bad++; $display("FAIL rmid_activity_after_reset: got %0d want 0", dcount); end
        // Second start mid-run must not restart the run nor change N.
        run_obs(7, 2, 0, 4, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 9) begin bad++; $display("FAIL busy_start_done_k: got %0d want 9", dk); end
        total++; if (cc !== 1) begin bad++; $display("FAIL busy_start_clr_cycles: got %0d want 1", cc); end
        total++; if (result !== 8'd8) begin bad++; $display("FAIL busy_start_result: got %0d want 8", result); end
        total++; if (term_idx !== 8'd6) begin bad++; $display("FAIL busy_start_term_idx: got %0d want 6", term_idx); end
        run_obs(4, 4, 0, 6, 1'b0, dk, dc, cc, ec, el, bc);
        total++; if (dk !== 6) begin bad++; $display("FAIL done_start_done_k: got %0d want 6", dk); end
        total++; if (dc !== 1 || cc !== 1) begin bad++; $display("FAIL done_start_ignored: got done=%0d clr=%0d want 1/1", dc, cc); end
    endtask

    task automatic test_random;
        int dk, dc, cc, ec, el, bc;
        int n, ak, e_dk, e_en, e_res, e_ovf, e_idx;
        bit sa;
        for (int it = 0; it < 25; it++) begin
            n  = $urandom_range(0, 24);
            sa = 1'($urandom_range(0, 1));
            ref_run(n, e_dk, e_en, e_res, e_ovf, e_idx);
            ak = 0;
            if (n > 0 && e_dk >= 3 && $urandom_range(0, 3) == 0)
                ak = $urandom_range(2, e_dk - 1);
            run_obs(n, $urandom_range(0, 255), ak, 0, sa, dk, dc, cc, ec, el, bc);
            if (ak != 0) begin
                total++; if (dc !== 0) begin bad++; $display("FAIL rnd%0d_abort_done: got %0d want 0", it, dc); end
                total++; if (ec !== ak - 2) begin bad++; $display("FAIL rnd%0d_abort_en: got %0d want %0d", it, ec, ak - 2); end
                total++; if (int'(term_idx) !== ak - 2) begin bad++; $display("FAIL rnd%0d_abort_idx: got %0d want %0d", it, term_idx, ak - 2); end
                total++; if (bc !== ak) begin bad++; $display("FAIL rnd%0d_abort_busy: got %0d want %0d", it, bc, ak); end
            end else begin
                total++; if (dk !== e_dk || dc !== 1) begin bad++; $display("FAIL rnd%0d_done: got k=%0d cnt=%0d want k=%0d cnt=1", it, dk, dc, e_dk); end
                total++; if (ec !== e_en) begin bad++; $display("FAIL rnd%0d_en: got %0d want %0d", it, ec, e_en); end
                total++; if (int'(result) !== e_res) begin bad++; $display("FAIL rnd%0d_result: got %0d want %0d", it, result, e_res); end
                total++; if (int'(ovf) !== e_ovf) begin bad++; $display("FAIL rnd%0d_ovf: got %0b want %0d", it, ovf, e_ovf); end
                total++; if (cc !== (n > 0 ? 1 : 0)) begin bad++; $display("FAIL rnd%0d_clr: got %0d want %0d", it, cc, (n > 0 ? 1 : 0)); end
                if (n > 0) begin
                    total++; if (int'(term_idx) !== e_idx) begin bad++; $display("FAIL rnd%0d_idx: got %0d want %0d", it, term_idx, e_idx); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_term();
        test_ten_terms();
        test_overflow();
        test_zero_terms();
        test_abort();
        test_start_with_abort();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
